// File: rtl/mar_seq.sv
// Memory address register with a load/step front end and a fixed-length
// read/write strobe sequencer (IDLE -> ACCESS -> DONE).
module mar_seq #(
  parameter int     AW      = 9,
  parameter int     VAL     = 0,
  parameter longint DEPTH   = 512,
  parameter int     WAIT    = 2,
  parameter bit     AUTOINC = 1'b0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [31:0]   dIn,
  input  logic          Rin,
  input  logic          inc,
  input  logic          dec,
  input  logic          rd,
  input  logic          wr,
  output logic [AW-1:0] address,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int              CW    = $clog2(WAIT + 1);
  localparam longint          LASTL = DEPTH - 1;
  localparam logic [AW:0]     LAST  = LASTL[AW:0];
  localparam logic [AW-1:0]   RST_A = VAL[AW-1:0];

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t        r_st    = S_IDLE;
  logic [CW-1:0] r_cnt   = '0;
  logic [AW-1:0] r_addr  = RST_A;
  logic          r_mrd   = 1'b0;
  logic          r_mwr   = 1'b0;
  logic          r_busy  = 1'b0;
  logic          r_done  = 1'b0;
  logic          r_err   = 1'b0;

  // Arithmetic one bit wider than the address so DEPTH = 2^AW compares cleanly.
  logic [AW:0]   w_nxt;
  logic [AW:0]   w_ld;
  logic [AW-1:0] w_inc_a;
  logic [AW-1:0] w_dec_a;
  logic          w_ld_ok;
  logic          w_unused;

  assign w_nxt    = {1'b0, r_addr} + (AW+1)'(1);
  assign w_inc_a  = (w_nxt > LAST) ? '0 : w_nxt[AW-1:0];
  assign w_dec_a  = (r_addr == '0) ? LAST[AW-1:0] : r_addr - AW'(1);
  assign w_ld     = {1'b0, dIn[AW-1:0]};
  assign w_ld_ok  = (w_ld <= LAST);
  assign w_unused = ^dIn;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_st   <= S_IDLE;
      r_cnt  <= '0;
      r_addr <= RST_A;
      r_mrd  <= 1'b0;
      r_mwr  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_done <= 1'b0;
      case (r_st)
        S_IDLE: begin
          if (rd ^ wr) begin
            r_st   <= S_ACC;
            r_cnt  <= CW'(1);
            r_mrd  <= rd;
            r_mwr  <= wr;
            r_busy <= 1'b1;
          end else if (rd && wr) begin
            r_err <= 1'b1;
          end else if (Rin) begin
            if (w_ld_ok) r_addr <= w_ld[AW-1:0];
            else         r_err  <= 1'b1;
          end else if (inc) begin
            r_addr <= w_inc_a;
          end else if (dec) begin
            r_addr <= w_dec_a;
          end
        end
        S_ACC: begin
          if (r_cnt == CW'(WAIT)) begin
            r_st   <= S_DONE;
            r_cnt  <= '0;
            r_mrd  <= 1'b0;
            r_mwr  <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_st   <= S_IDLE;
          r_busy <= 1'b0;
          if (AUTOINC) r_addr <= w_inc_a;
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

  assign address = r_addr;
  assign mem_rd  = r_mrd;
  assign mem_wr  = r_mwr;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_mar_seq.sv
// Two mar_seq configurations driven in parallel, checked against a
// cycle-count reference model plus directed expectations.
module tb_mar_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] dIn = '0;
  logic        Rin = 1'b0, inc = 1'b0, dec = 1'b0, rd = 1'b0, wr = 1'b0;

  logic [1:0][8:0] addr_o;
  logic [1:0]      mrd_o, mwr_o, busy_o, done_o, err_o;

  int n_vec = 0;
  int n_err = 0;

  // Configurations: 0 = DEPTH 512, WAIT 2, AUTOINC, VAL 0; 1 = DEPTH 300, WAIT 3, VAL 5.
  int D[2]  = '{512, 300};
  int W[2]  = '{2, 3};
  int AI[2] = '{1, 0};
  int V[2]  = '{0, 5};

  // Model: t = cycles since the access was accepted (0 = idle).
  int m_addr[2];
  int m_t[2];
  int m_op[2];
  int m_err[2];

  mar_seq #(.AW(9), .VAL(0), .DEPTH(512), .WAIT(2), .AUTOINC(1'b1)) u0 (
    .clk(clk), .clr(clr), .dIn(dIn), .Rin(Rin), .inc(inc), .dec(dec),
    .rd(rd), .wr(wr), .address(addr_o[0]), .mem_rd(mrd_o[0]),
    .mem_wr(mwr_o[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]));

  mar_seq #(.AW(9), .VAL(5), .DEPTH(300), .WAIT(3), .AUTOINC(1'b0)) u1 (
    .clk(clk), .clr(clr), .dIn(dIn), .Rin(Rin), .inc(inc), .dec(dec),
    .rd(rd), .wr(wr), .address(addr_o[1]), .mem_rd(mrd_o[1]),
    .mem_wr(mwr_o[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = V[k]; m_t[k] = 0; m_op[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic mstep(input int k);
    int v;
    m_err[k] = 0;
    if (m_t[k] > 0) begin
      if (m_t[k] == W[k] + 1) begin
        m_t[k] = 0;
        if (AI[k] != 0) m_addr[k] = (m_addr[k] + 1) % D[k];
      end else m_t[k]++;
    end else if (rd != wr) begin
      m_t[k] = 1; m_op[k] = wr ? 1 : 0;
    end else if (rd && wr) begin
      m_err[k] = 1;
    end else if (Rin) begin
      v = int'(dIn % 512);
      if (v < D[k]) m_addr[k] = v;
      else          m_err[k] = 1;
    end else if (inc) begin
      m_addr[k] = (m_addr[k] + 1) % D[k];
    end else if (dec) begin
      m_addr[k] = (m_addr[k] + D[k] - 1) % D[k];
    end
  endtask

  task automatic mcheck(input int k);
    logic strobe;
    strobe = (m_t[k] >= 1) && (m_t[k] <= W[k]);
    chk($sformatf("addr%0d", k), 32'(addr_o[k]), 32'(m_addr[k]));
    chk($sformatf("mrd%0d", k),  32'(mrd_o[k]),  32'(strobe && m_op[k] == 0));
    chk($sformatf("mwr%0d", k),  32'(mwr_o[k]),  32'(strobe && m_op[k] == 1));
    chk($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(m_t[k] > 0));
    chk($sformatf("done%0d", k), 32'(done_o[k]), 32'(m_t[k] == W[k] + 1));
    chk($sformatf("err%0d", k),  32'(err_o[k]),  32'(m_err[k]));
  endtask

  // Called at a negedge: apply inputs, clock once, check at the next negedge.
  task automatic cyc(input logic r_in, input logic [31:0] d, input logic i_inc,
                     input logic i_dec, input logic i_rd, input logic i_wr);
    Rin = r_in; dIn = d; inc = i_inc; dec = i_dec; rd = i_rd; wr = i_wr;
    @(posedge clk);
    mstep(0); mstep(1);
    @(negedge clk);
    mcheck(0); mcheck(1);
    Rin = 0; inc = 0; dec = 0; rd = 0; wr = 0;
  endtask

  // Asynchronous clear pulse between edges; outputs must react with no clock.
  task automatic pulse_clr();
    #1 clr = 1'b1;
    #1 mreset();
    mcheck(0); mcheck(1);
    chk("clr_addr0", 32'(addr_o[0]), 32'd0);
    chk("clr_busy0", 32'(busy_o[0]), 32'd0);
    chk("clr_mrd0",  32'(mrd_o[0]),  32'd0);
    #1 clr = 1'b0;
  endtask

  initial begin
    mreset();
    repeat (2) @(negedge clk);
    mcheck(0); mcheck(1);
    chk("rst_addr1", 32'(addr_o[1]), 32'd5);
    clr = 1'b0;

    cyc(1, 32'h0000_0A05, 0, 0, 0, 0);
    chk("load_addr0", 32'(addr_o[0]), 32'h005);
    chk("load_err0",  32'(err_o[0]),  32'd0);

    cyc(1, 32'h0000_012C, 0, 0, 0, 0);
    chk("range_err1",  32'(err_o[1]),  32'd1);
    chk("range_addr1", 32'(addr_o[1]), 32'd5);
    chk("range_addr0", 32'(addr_o[0]), 32'h12C);
    cyc(0, 0, 0, 0, 0, 0);
    chk("range_err1_clr", 32'(err_o[1]), 32'd0);

    cyc(1, 32'h1FF, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("wrap_inc0", 32'(addr_o[0]), 32'd0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("wrap_dec0", 32'(addr_o[0]), 32'd511);
    cyc(1, 32'h3, 1, 0, 0, 0);
    chk("rin_prio0", 32'(addr_o[0]), 32'd3);

    cyc(1, 32'h40, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("rd_c1_mrd",  32'(mrd_o[0]),  32'd1);
    chk("rd_c1_busy", 32'(busy_o[0]), 32'd1);
    cyc(1, 32'h7, 1, 0, 0, 0);
    chk("rd_c2_mrd",  32'(mrd_o[0]),  32'd1);
    chk("rd_c2_addr", 32'(addr_o[0]), 32'h40);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rd_c3_done", 32'(done_o[0]), 32'd1);
    chk("rd_c3_mrd",  32'(mrd_o[0]),  32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rd_c4_addr", 32'(addr_o[0]), 32'h41);
    chk("rd_c4_busy", 32'(busy_o[0]), 32'd0);
    cyc(0, 0, 0, 0, 0, 0);

    cyc(0, 0, 0, 0, 1, 0);
    chk("abort_busy0", 32'(busy_o[0]), 32'd1);
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("abort_nodone0", 32'(done_o[0]), 32'd0);
    end

    cyc(0, 0, 0, 0, 1, 1);
    chk("conf_err0",  32'(err_o[0]),  32'd1);
    chk("conf_mrd0",  32'(mrd_o[0]),  32'd0);
    chk("conf_mwr0",  32'(mwr_o[0]),  32'd0);
    chk("conf_busy0", 32'(busy_o[0]), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 50 == 0) pulse_clr();
      cyc(($urandom % 5) == 0,
          ($urandom << 9) | 32'($urandom_range(0, 511)),
          ($urandom % 4) == 0, ($urandom % 4) == 0,
          ($urandom % 8) == 0, ($urandom % 8) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mar_seq.md
MAR_SEQ -- requirements
Module: mar_seq

Interface
REQ-001 SHALL have parameter AW, default 9, address width in bits (1..32).
REQ-002 SHALL have parameter VAL, default 0, reset/initial address value (< DEPTH).
REQ-003 SHALL have parameter DEPTH, default 512, number of valid addresses (2..2^AW).
REQ-004 SHALL have parameter WAIT, default 2, memory strobe length in cycles (>= 1).
REQ-005 SHALL have parameter AUTOINC, default 0; when 1, the address post-increments after each access.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port clr, input, 1, reset; asynchronous and active-high.
REQ-008 SHALL have port dIn, input, 32, load data; only dIn[AW-1:0] is used.
REQ-009 SHALL have port Rin, input, 1, load request.
REQ-010 SHALL have ports inc and dec, input, 1 each, step the address by +1 and -1.
REQ-011 SHALL have ports rd and wr, input, 1 each, start a read or write access.
REQ-012 SHALL have port address, output, AW, the current memory address (registered).
REQ-013 SHALL have ports mem_rd and mem_wr, output, 1 each, memory strobes (registered).
REQ-014 SHALL have ports busy, done and err, output, 1 each (registered).

Function
REQ-015 SHALL implement a three-state FSM:
- IDLE: busy=0.
- ACCESS: busy=1, strobe high.
- DONE: busy=1, done=1 for exactly one cycle.
REQ-016 In IDLE, address-update priority SHALL be Rin > inc > dec; one update per cycle at most.
REQ-017 Load rule:
- dIn[AW-1:0] < DEPTH: address <= dIn[AW-1:0].
- Otherwise: address unchanged, err=1 for one cycle.
REQ-018 inc SHALL give address+1, wrapping DEPTH-1 -> 0; dec SHALL give address-1, wrapping 0 -> DEPTH-1.
REQ-019 rd or wr alone in IDLE SHALL enter ACCESS next cycle; any Rin/inc/dec in that same cycle SHALL be ignored.
REQ-020 rd and wr together in IDLE SHALL start no access, leave address unchanged, stay in IDLE, and pulse err for one cycle.
REQ-021 In ACCESS, the matching strobe (mem_rd for rd, mem_wr for wr) SHALL be high for exactly WAIT consecutive cycles, the other strobe 0, address frozen.
REQ-022 A counter of width $clog2(WAIT+1) SHALL time ACCESS; after WAIT cycles the FSM SHALL move to DONE with both strobes 0.
REQ-023 DONE SHALL return to IDLE on the next edge; if AUTOINC=1, the address SHALL increment with REQ-018 wrap on the DONE->IDLE edge.
REQ-024 Rin, inc, dec, rd and wr SHALL be ignored while busy=1 (no queuing, no err).
REQ-025 Back-to-back rd/wr SHALL take WAIT+2 cycles from the request edge to the next accepted request.
REQ-026 Address arithmetic SHALL be done at AW+1 bits before the wrap compare, so no intermediate overflow occurs for DEPTH = 2^AW.

Reset
REQ-027 clr=1 SHALL immediately, without waiting for a clock edge, set: address=VAL, state=IDLE, counter=0, and mem_rd, mem_wr, busy, done, err all 0.
REQ-028 clr asserted during ACCESS or DONE SHALL abort the access; no done pulse follows after clr deasserts.
REQ-029 The first rising edge after clr falls SHALL be processed as a normal IDLE cycle.
REQ-030 The initial simulation value of all registers SHALL equal their reset values.

Verification (AW=9, VAL=0, WAIT=2 unless stated)
REQ-031 Load: Rin=1, dIn=0x00000A05 -> address=0x005 next cycle, err=0.
REQ-032 Range check (DEPTH=300): Rin=1, dIn=0x12C -> address unchanged, err=1 one cycle.
REQ-033 Wrap: address=511, inc -> 0; then dec -> 511; Rin+inc together -> load only.
REQ-034 Read (AUTOINC=1): address=0x040, rd pulse -> mem_rd=1 for two cycles, done=1 on the third, mem_rd=0, address=0x041 the following cycle.
REQ-035 Abort: clr=1 mid-ACCESS -> address=0, mem_rd=0 and busy=0 without a clock edge; no done afterwards.
REQ-036 Conflict: rd=wr=1 in IDLE -> err=1 one cycle, no strobes, busy=0.
